phase_sequencer: RTL and testbench

- Generates the five-phase instruction timing that drives the SIMPLE processor datapath: P1 fetch, P2 decode/register read, P3 execute, P4 memory, P5 writeback.
- Sits directly upstream of the processor datapath and feeds its phase strobes.
- Adds run/stop control from the exec button, single-step, HLT-instruction halt, memory stall, and a retired-instruction counter.

---
 rtl/phase_sequencer.sv | 150 +++++++++++++++
 tb/tb_phase_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Five-phase instruction timing generator for the SIMPLE processor datapath:
//   P1 fetch, P2 decode/register read, P3 execute, P4 memory, P5 writeback.
//   Run/stop comes from the exec pushbutton and single-step from the step
//   pushbutton. The sequencer halts on an HLT instruction, waits on memory
//   stalls in P1/P4, and counts retired instructions.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   exec         in   run/stop pushbutton (asynchronous level)
//   step         in   single-step pushbutton (asynchronous level)
//   halt_req     in   current instruction is HLT (looked at in P5 only)
//   stall        in   memory wait (honoured in P1 and P4 only)
//   phase        out  binary phase index 0..4 = P1..P5, 0 while halted
//   phase_bus    out  one-hot phase strobe, 0 while halted
//   reset_ps     out  datapath reset, released on the first edge after reset
//   running      out  high whenever a phase strobe is active
//   instr_count  out  number of completed P5 phases (wraps)
// -----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int NPHASE = 5,   // only 5 is supported
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
  input  logic             step,
  input  logic             halt_req,
  input  logic             stall,
  output logic [3:0]       phase,
  output logic [4:0]       phase_bus,
  output logic             reset_ps,
  output logic             running,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  localparam logic [3:0] PH_P1 = 4'd0;
  localparam logic [3:0] PH_P4 = 4'd3;
  localparam logic [3:0] PH_P5 = 4'(NPHASE - 1);

  state_e           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [4:0]       bus_q, bus_d;
  logic             running_q, running_d;
  logic             stop_pend_q, stop_pend_d;
  logic             reset_ps_q, reset_ps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Button conditioning: bit0/bit1 form the two-flop synchroniser, bit2 is a
  // delayed copy of bit1 so a held button produces a single one-cycle pulse.
  logic [2:0] exec_sh_q, exec_sh_d;
  logic [2:0] step_sh_q, step_sh_d;
  logic       exec_pulse, step_pulse;

  assign exec_sh_d  = {exec_sh_q[1:0], exec};
  assign step_sh_d  = {step_sh_q[1:0], step};
  assign exec_pulse = exec_sh_q[1] & ~exec_sh_q[2];
  assign step_pulse = step_sh_q[1] & ~step_sh_q[2];

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    stop_pend_d = stop_pend_q;
    cnt_d       = cnt_q;
    reset_ps_d  = 1'b0;

    case (state_q)
      S_HALT: begin
        // exec has priority when both buttons pulse in the same cycle.
        if (exec_pulse) begin
          state_d = S_RUN;
          phase_d = PH_P1;
        end else if (step_pulse) begin
          state_d = S_STEP;
          phase_d = PH_P1;
        end
      end

      default: begin
        // A stop request is only remembered; the instruction always finishes.
        if (state_q == S_RUN && exec_pulse) begin
          stop_pend_d = 1'b1;
        end

        if (phase_q == PH_P5) begin
          cnt_d   = cnt_q + CNT_W'(1);
          phase_d = PH_P1;
          if (halt_req || stop_pend_q || state_q == S_STEP) begin
            state_d     = S_HALT;
            stop_pend_d = 1'b0;
          end
        end else if ((phase_q == PH_P1 || phase_q == PH_P4) && stall) begin
          phase_d = phase_q;
        end else if (phase_q > PH_P5) begin
          phase_d = PH_P1;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
    endcase

    // Strobe and running flag are derived from the next state so that they
    // are registered alongside phase and change on the same edge.
    bus_d     = (state_d == S_HALT) ? 5'b00000 : (5'b00001 << phase_d);
    running_d = (state_d != S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_HALT;
      phase_q     <= PH_P1;
      bus_q       <= 5'b00000;
      running_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      reset_ps_q  <= 1'b1;
      cnt_q       <= '0;
      exec_sh_q   <= 3'b000;
      step_sh_q   <= 3'b000;
    end else begin
      state_q     <= state_d;
      phase_q     <= (state_d == S_HALT) ? PH_P1 : phase_d;
      bus_q       <= bus_d;
      running_q   <= running_d;
      stop_pend_q <= stop_pend_d;
      reset_ps_q  <= reset_ps_d;
      cnt_q       <= cnt_d;
      exec_sh_q   <= exec_sh_d;
      step_sh_q   <= step_sh_d;
    end
  end

  assign phase       = phase_q;
  assign phase_bus   = bus_q;
  assign running     = running_q;
  assign reset_ps    = reset_ps_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//   Directed bench for phase_sequencer. The stimulus process pushes the
//   expected outputs for each cycle it cares about into a queue; a monitor
//   pops one entry per falling clock edge (or per explicit probe event for
//   between-edge checks) and compares. A second instance with a 4-bit
//   counter shares all inputs and exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset, exec, step, halt_req, stall;
  logic [3:0]  phase, phase_w;
  logic [4:0]  phase_bus, phase_bus_w;
  logic        reset_ps, reset_ps_w, running, running_w;
  logic [15:0] instr_count;
  logic [3:0]  instr_count_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [4:0]  bus;
    logic [15:0] cnt;
    logic        rps;
  } exp_t;

  exp_t exp_q[$];
  event mon_ev;

  always #5 clock = ~clock;

  phase_sequencer #(.NPHASE(5), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .exec(exec), .step(step),
    .halt_req(halt_req), .stall(stall), .phase(phase),
    .phase_bus(phase_bus), .reset_ps(reset_ps), .running(running),
    .instr_count(instr_count)
  );

  phase_sequencer #(.NPHASE(5), .CNT_W(4)) dut_w (
    .clock(clock), .reset(reset), .exec(exec), .step(step),
    .halt_req(halt_req), .stall(stall), .phase(phase_w),
    .phase_bus(phase_bus_w), .reset_ps(reset_ps_w), .running(running_w),
    .instr_count(instr_count_w)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [4:0] bus, input int cnt, input logic rps);
    exp_t e;
    e.nm  = nm;
    e.bus = bus;
    e.cnt = 16'(cnt);
    e.rps = rps;
    exp_q.push_back(e);
  endtask

  // Advance one rising edge, then record what the outputs must be for the
  // cycle that edge starts.
  task automatic cyc(input string nm, input logic [4:0] bus, input int cnt, input logic rps = 1'b0);
    @(posedge clock);
    #1;
    push(nm, bus, cnt, rps);
  endtask

  // Immediate check between clock edges.
  task automatic probe(input string nm, input logic [4:0] bus, input int cnt, input logic rps);
    push(nm, bus, cnt, rps);
    -> mon_ev;
  endtask

  // Monitor: consumes one expectation per falling edge or probe.
  initial begin
    exp_t       e;
    logic [3:0] exp_ph;
    forever begin
      @(negedge clock or mon_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        exp_ph = 4'd0;
        for (int i = 0; i < 5; i++) if (e.bus[i]) exp_ph = 4'(i);
        check({e.nm, ".phase_bus"}, 32'(phase_bus), 32'(e.bus));
        check({e.nm, ".phase"}, 32'(phase), 32'(exp_ph));
        check({e.nm, ".running"}, 32'(running), 32'(e.bus != 5'b0));
        check({e.nm, ".reset_ps"}, 32'(reset_ps), 32'(e.rps));
        check({e.nm, ".instr_count"}, 32'(instr_count), 32'(e.cnt));
        check({e.nm, ".w_phase_bus"}, 32'(phase_bus_w), 32'(e.bus));
        check({e.nm, ".w_phase"}, 32'(phase_w), 32'(exp_ph));
        check({e.nm, ".w_running"}, 32'(running_w), 32'(e.bus != 5'b0));
        check({e.nm, ".w_reset_ps"}, 32'(reset_ps_w), 32'(e.rps));
        check({e.nm, ".w_instr_count"}, 32'(instr_count_w), 32'(e.cnt[3:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; exec = 1'b0; step = 1'b0; halt_req = 1'b0; stall = 1'b0;

    // 1. Reset state, reset_ps release, start from exec held high.
    #2 probe("reset_state", 5'b00000, 0, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    push("reset_ps_hold", 5'b00000, 0, 1'b1);
    cyc("reset_ps_clr", 5'b00000, 0);
    exec = 1'b1;
    cyc("t1_sync_a", 5'b00000, 0);
    cyc("t1_sync_b", 5'b00000, 0);
    cyc("t1_p1", 5'b00001, 0);
    cyc("t1_p2", 5'b00010, 0);
    cyc("t1_p3", 5'b00100, 0);
    cyc("t1_p4", 5'b01000, 0);
    cyc("t1_p5", 5'b10000, 0);
    cyc("t1_p1_next", 5'b00001, 1);

    // 4b. exec pulse during P2 finishes the instruction then halts.
    exec = 1'b0;
    cyc("t4s_p2a", 5'b00010, 1);
    cyc("t4s_p3a", 5'b00100, 1);
    cyc("t4s_p4a", 5'b01000, 1);
    cyc("t4s_p5a", 5'b10000, 1);
    exec = 1'b1;
    cyc("t4s_p1", 5'b00001, 2);
    cyc("t4s_p2", 5'b00010, 2);
    cyc("t4s_p3", 5'b00100, 2);
    cyc("t4s_p4", 5'b01000, 2);
    cyc("t4s_p5", 5'b10000, 2);
    cyc("t4s_halt", 5'b00000, 3);
    cyc("t4s_halt_stay", 5'b00000, 3);
    exec = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t4s_idle", 5'b00000, 3);
    exec = 1'b1;
    cyc("t4s_resync_a", 5'b00000, 3);
    cyc("t4s_resync_b", 5'b00000, 3);
    cyc("t4s_restart_p1", 5'b00001, 3);

    // 3. Stall: ignored in P3, holds P4 for four cycles, holds P1.
    cyc("t3_p2", 5'b00010, 3);
    cyc("t3_p3", 5'b00100, 3);
    stall = 1'b1;
    cyc("t3_p4_0", 5'b01000, 3);
    cyc("t3_p4_1", 5'b01000, 3);
    cyc("t3_p4_2", 5'b01000, 3);
    cyc("t3_p4_3", 5'b01000, 3);
    stall = 1'b0;
    cyc("t3_p5", 5'b10000, 3);
    cyc("t3_p1", 5'b00001, 4);
    stall = 1'b1;
    cyc("t3_p1_hold", 5'b00001, 4);
    stall = 1'b0;
    cyc("t3_p2b", 5'b00010, 4);
    cyc("t3_p3b", 5'b00100, 4);
    cyc("t3_p4b", 5'b01000, 4);
    cyc("t3_p5b", 5'b10000, 4);
    cyc("t3_p1c", 5'b00001, 5);

    // 4a. halt_req acts only at the end of P5; stall ignored in P5.
    halt_req = 1'b1;
    cyc("t4h_p2", 5'b00010, 5);
    cyc("t4h_p3", 5'b00100, 5);
    cyc("t4h_p4", 5'b01000, 5);
    cyc("t4h_p5", 5'b10000, 5);
    stall = 1'b1;
    cyc("t4h_halt", 5'b00000, 6);
    stall = 1'b0;
    halt_req = 1'b0;
    cyc("t4h_halt_stay", 5'b00000, 6);

    // 2. Single step: one instruction then back to HALT.
    exec = 1'b0;
    step = 1'b1;
    cyc("t2_sync_a", 5'b00000, 6);
    cyc("t2_sync_b", 5'b00000, 6);
    cyc("t2_p1", 5'b00001, 6);
    cyc("t2_p2", 5'b00010, 6);
    cyc("t2_p3", 5'b00100, 6);
    cyc("t2_p4", 5'b01000, 6);
    cyc("t2_p5", 5'b10000, 6);
    cyc("t2_halt", 5'b00000, 7);
    cyc("t2_halt_stay_a", 5'b00000, 7);
    cyc("t2_halt_stay_b", 5'b00000, 7);

    // 6b. Simultaneous exec and step: exec wins, RUN continues past P5.
    step = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t6_idle", 5'b00000, 7);
    exec = 1'b1;
    step = 1'b1;
    cyc("t6_sync_a", 5'b00000, 7);
    cyc("t6_sync_b", 5'b00000, 7);
    cyc("t6_p1", 5'b00001, 7);
    cyc("t6_p2", 5'b00010, 7);
    cyc("t6_p3", 5'b00100, 7);
    cyc("t6_p4", 5'b01000, 7);
    cyc("t6_p5", 5'b10000, 7);
    cyc("t6_past_p5", 5'b00001, 8);

    // 6a. Run on until the 4-bit counter wraps from 15 to 0.
    for (int c = 8; c < 16; c++) begin
      cyc("wrap_p2", 5'b00010, c);
      cyc("wrap_p3", 5'b00100, c);
      cyc("wrap_p4", 5'b01000, c);
      cyc("wrap_p5", 5'b10000, c);
      cyc("wrap_p1", 5'b00001, c + 1);
    end

    // 5. Asynchronous reset in the middle of P3.
    cyc("t5_p2", 5'b00010, 16);
    cyc("t5_p3", 5'b00100, 16);
    #5;
    reset = 1'b1;
    #1 probe("t5_async_reset", 5'b00000, 0, 1'b1);
    cyc("t5_reset_held", 5'b00000, 0, 1'b1);
    reset = 1'b0;
    exec = 1'b0;
    step = 1'b0;
    cyc("t5_rps_clear", 5'b00000, 0);

    repeat (3) @(negedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
